// File: rtl/multi_shift_unit.sv
// multi_shift_unit: multi-channel history shifter.
// Each channel keeps the last DEPTH bytes pushed and returns an XLEN-bit
// window of that history, shifted left or right by a saturating amount,
// optionally bit-reversed. Reads are registered with one cycle of latency.
module multi_shift_unit #(
  parameter int XLEN      = 8,
  parameter int DEPTH     = 2,
  parameter int CHANNELS  = 1,
  parameter int AMT_WIDTH = $clog2((DEPTH-1)*XLEN+1),
  parameter int CH_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [1:0]                             wr_sel,
  input  logic [CH_WIDTH-1:0]                    wr_ch,
  input  logic [XLEN-1:0]                        wdata,
  input  logic                                   rd_en,
  input  logic [CH_WIDTH-1:0]                    rd_ch,
  output logic [XLEN-1:0]                        rdata,
  output logic                                   rd_valid,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0]    fill
);

  localparam int FILL_WIDTH = $clog2(DEPTH+1);
  localparam int VEC_WIDTH  = DEPTH*XLEN;
  // Largest shift that still keeps part of the history inside the window.
  localparam int MAX_SHIFT  = (DEPTH-1)*XLEN;

  localparam logic [1:0] SEL_PUSH  = 2'd0;
  localparam logic [1:0] SEL_AMT   = 2'd1;
  localparam logic [1:0] SEL_MODE  = 2'd2;
  localparam logic [1:0] SEL_CLEAR = 2'd3;

  // Per-channel views collected for the shared read path.
  logic [VEC_WIDTH-1:0] ch_vec  [CHANNELS];
  logic [AMT_WIDTH-1:0] ch_amt  [CHANNELS];
  logic [1:0]           ch_mode [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [XLEN-1:0]       word_reg [DEPTH];
      logic [AMT_WIDTH-1:0]  amt_reg;
      logic [1:0]            mode_reg;
      logic [FILL_WIDTH-1:0] fill_reg;
      logic [VEC_WIDTH-1:0]  vec;
      logic                  wr_hit;

      // Indices beyond CHANNELS never match any channel, so such writes vanish.
      assign wr_hit = wr_en && (wr_ch == CH_WIDTH'(gi));

      // Channel state: history push, amount, mode and clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            word_reg[k] <= '0;
          end
          amt_reg  <= '0;
          mode_reg <= '0;
          fill_reg <= '0;
        end else if (wr_hit) begin
          case (wr_sel)
            SEL_PUSH: begin
              for (int k = 0; k < DEPTH-1; k++) begin
                word_reg[k] <= word_reg[k+1];
              end
              word_reg[DEPTH-1] <= wdata;
              if (fill_reg != FILL_WIDTH'(DEPTH)) begin
                fill_reg <= fill_reg + 1'b1;
              end
            end
            SEL_AMT: begin
              amt_reg <= wdata[AMT_WIDTH-1:0];
            end
            SEL_MODE: begin
              mode_reg <= wdata[1:0];
            end
            SEL_CLEAR: begin
              // Amount and mode survive a clear; only the history is wiped.
              for (int k = 0; k < DEPTH; k++) begin
                word_reg[k] <= '0;
              end
              fill_reg <= '0;
            end
            default: begin
            end
          endcase
        end
      end

      // Concatenate history with the newest word in the most significant slot.
      always_comb begin
        vec = '0;
        for (int k = 0; k < DEPTH; k++) begin
          vec[k*XLEN +: XLEN] = word_reg[k];
        end
      end

      assign ch_vec[gi]  = vec;
      assign ch_amt[gi]  = amt_reg;
      assign ch_mode[gi] = mode_reg;
      assign fill[gi*FILL_WIDTH +: FILL_WIDTH] = fill_reg;
    end
  endgenerate

  logic                 rd_ok;
  logic [VEC_WIDTH-1:0] sel_vec;
  logic [AMT_WIDTH-1:0] sel_amt;
  logic [1:0]           sel_mode;
  logic [AMT_WIDTH-1:0] eff_amt;
  logic [XLEN-1:0]      raw_left;
  logic [XLEN-1:0]      raw_right;
  logic [XLEN-1:0]      raw_sel;
  logic [XLEN-1:0]      result_next;
  logic [XLEN-1:0]      rdata_reg;
  logic                 rd_valid_reg;

  // Select the addressed channel and form the shifted, optionally reversed window.
  always_comb begin
    // Extra bit keeps the bound check correct when CHANNELS == 2**CH_WIDTH.
    rd_ok    = rd_en && ({1'b0, rd_ch} < (CH_WIDTH+1)'(CHANNELS));
    sel_vec  = '0;
    sel_amt  = '0;
    sel_mode = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_WIDTH'(c)) begin
        sel_vec  = ch_vec[c];
        sel_amt  = ch_amt[c];
        sel_mode = ch_mode[c];
      end
    end
    eff_amt   = (sel_amt > AMT_WIDTH'(MAX_SHIFT)) ? AMT_WIDTH'(MAX_SHIFT) : sel_amt;
    raw_left  = XLEN'((sel_vec << eff_amt) >> MAX_SHIFT);
    raw_right = XLEN'(sel_vec >> eff_amt);
    raw_sel   = sel_mode[0] ? raw_right : raw_left;
    result_next = '0;
    for (int i = 0; i < XLEN; i++) begin
      result_next[i] = sel_mode[1] ? raw_sel[XLEN-1-i] : raw_sel[i];
    end
  end

  // Output register: result captured only on an accepted read, valid pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_ok;
      if (rd_ok) begin
        rdata_reg <= result_next;
      end
    end
  end

  assign rdata    = rdata_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_multi_shift_unit.sv
// tb_multi_shift_unit: directed plan plus randomized traffic against a
// behavioural history model; a negedge monitor scores every rd_valid pulse.
module tb_multi_shift_unit;

  localparam int XLEN     = 8;
  localparam int DEPTH    = 2;
  localparam int CHANNELS = 2;
  localparam int CHW      = 2;   // wide enough to address out-of-range channels 2 and 3
  localparam int AMTW     = 4;
  localparam int FW       = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_en;
  logic [1:0]               wr_sel;
  logic [CHW-1:0]           wr_ch;
  logic [XLEN-1:0]          wdata;
  logic                     rd_en;
  logic [CHW-1:0]           rd_ch;
  logic [XLEN-1:0]          rdata;
  logic                     rd_valid;
  logic [CHANNELS*FW-1:0]   fill;

  logic [XLEN-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: byte history per channel, oldest first.
  logic [XLEN-1:0] m_w    [CHANNELS][DEPTH];
  logic [AMTW-1:0] m_amt  [CHANNELS];
  logic [1:0]      m_mode [CHANNELS];
  int              m_fill [CHANNELS];

  multi_shift_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .AMT_WIDTH(AMTW), .CH_WIDTH(CHW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch),
    .wdata(wdata), .rd_en(rd_en), .rd_ch(rd_ch), .rdata(rdata),
    .rd_valid(rd_valid), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < DEPTH; k++) m_w[c][k] = '0;
      m_amt[c]  = '0;
      m_mode[c] = '0;
      m_fill[c] = 0;
    end
  endtask

  task automatic model_write(int sel, int ch, int d);
    if (ch >= CHANNELS) return;
    case (sel)
      0: begin
        for (int k = 0; k < DEPTH-1; k++) m_w[ch][k] = m_w[ch][k+1];
        m_w[ch][DEPTH-1] = XLEN'(d);
        if (m_fill[ch] < DEPTH) m_fill[ch]++;
      end
      1: m_amt[ch]  = AMTW'(d);
      2: m_mode[ch] = 2'(d);
      default: begin
        for (int k = 0; k < DEPTH; k++) m_w[ch][k] = '0;
        m_fill[ch] = 0;
      end
    endcase
  endtask

  // Window value from plain integer arithmetic on the history.
  function automatic logic [XLEN-1:0] model_read(int ch);
    logic [63:0]     v;
    int              e;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] o;
    v = 0;
    for (int k = DEPTH-1; k >= 0; k--) v = (v << XLEN) | 64'(m_w[ch][k]);
    e = int'(m_amt[ch]);
    if (e > (DEPTH-1)*XLEN) e = (DEPTH-1)*XLEN;
    if (m_mode[ch][0]) r = XLEN'(v >> e);
    else               r = XLEN'((v << e) >> ((DEPTH-1)*XLEN));
    for (int i = 0; i < XLEN; i++) o[i] = m_mode[ch][1] ? r[XLEN-1-i] : r[i];
    return o;
  endfunction

  function automatic logic [CHANNELS*FW-1:0] model_fill();
    logic [CHANNELS*FW-1:0] f;
    f = '0;
    for (int c = 0; c < CHANNELS; c++) f[c*FW +: FW] = FW'(m_fill[c]);
    return f;
  endfunction

  // One bus cycle: predict the read from pre-write state, then apply the write.
  task automatic do_cycle(bit we, int sel, int wch, int wd, bit re, int rch,
                          bit use_exp, logic [XLEN-1:0] exp_v);
    if (re && rch < CHANNELS) exp_q.push_back(use_exp ? exp_v : model_read(rch));
    if (we) model_write(sel, wch, wd);
    wr_en  = we;
    wr_sel = 2'(sel);
    wr_ch  = CHW'(wch);
    wdata  = XLEN'(wd);
    rd_en  = re;
    rd_ch  = CHW'(rch);
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("fill_vs_model", 32'(fill), 32'(model_fill()));
  endtask

  task automatic wr(int sel, int ch, int d);
    do_cycle(1'b1, sel, ch, d, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic rd(int ch, logic [XLEN-1:0] req);
    do_cycle(1'b0, 0, 0, 0, 1'b1, ch, 1'b1, req);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, '0);
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'(0));
      end else begin
        logic [XLEN-1:0] e;
        e = exp_q.pop_front();
        $display("read: rdata=0x%02h expected=0x%02h", rdata, e);
        check("rdata", 32'(rdata), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_ch = '0; wdata = '0; rd_en = 1'b0; rd_ch = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_rdata", 32'(rdata), 32'(0));
    check("reset_rd_valid", 32'(rd_valid), 32'(0));
    check("reset_fill", 32'(fill), 32'(0));

    // Reset state read
    rd(0, 8'h00);
    idle(1);

    // Legacy-compatible left shift
    wr(0, 0, 'hAB);
    wr(0, 0, 'hCD);
    check("fill0_after_two_pushes", 32'(fill[1:0]), 32'(2));
    wr(1, 0, 3);
    rd(0, 8'h6D);
    wr(1, 0, 0);
    rd(0, 8'hCD);

    // Right mode and reverse
    wr(2, 0, 1);
    wr(1, 0, 3);
    rd(0, 8'hB5);
    wr(2, 0, 2);
    rd(0, 8'hB6);

    // Saturation and discard
    wr(2, 0, 0);
    wr(1, 0, 15);
    rd(0, 8'hAB);
    wr(0, 0, 'h12);
    check("fill0_saturated", 32'(fill[1:0]), 32'(2));
    wr(1, 0, 8);
    rd(0, 8'hCD);

    // Channel isolation and clear
    wr(0, 1, 'h55);
    rd(0, 8'hCD);
    wr(1, 1, 4);
    wr(2, 1, 1);
    rd(1, 8'h50);
    check("fill_ch1_one", 32'(fill), 32'(4'b0110));
    wr(3, 1, 0);
    rd(1, 8'h00);
    check("fill_ch1_cleared", 32'(fill), 32'(4'b0010));
    wr(0, 1, 'hF0);
    wr(0, 1, 'h0F);
    rd(1, 8'hFF);   // amount 4 / right mode survived the clear

    // Out-of-range channel indices
    wr(0, 2, 'h99);
    wr(1, 3, 0);
    wr(3, 2, 0);
    wr(3, 3, 0);
    rd(0, 8'hCD);
    rd(1, 8'hFF);
    check("fill_after_bad_ch", 32'(fill), 32'(4'b1010));
    do_cycle(1'b0, 0, 0, 0, 1'b1, 2, 1'b0, '0);
    do_cycle(1'b0, 0, 0, 0, 1'b1, 3, 1'b0, '0);
    idle(1);

    // Same-cycle read and write
    wr(1, 0, 0);
    do_cycle(1'b1, 0, 0, 'h77, 1'b1, 0, 1'b1, 8'h12);
    rd(0, 8'h77);
    idle(2);

    // Reset asserted while a read result is pending
    rd_en = 1'b1; rd_ch = '0;
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_rd_valid", 32'(rd_valid), 32'(0));
    check("midreset_rdata", 32'(rdata), 32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    check("post_reset_rd_valid", 32'(rd_valid), 32'(0));
    check("post_reset_rdata", 32'(rdata), 32'(0));

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      bit we, re;
      int sel, wch, wd, rch;
      we  = ($urandom_range(0, 99) < 60);
      sel = ($urandom_range(0, 99) < 8) ? 3 : int'($urandom_range(0, 2));
      wch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      wd  = int'($urandom_range(0, 255));
      re  = ($urandom_range(0, 99) < 60);
      rch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      do_cycle(we, sel, wch, wd, re, rch, 1'b0, '0);
    end

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
